// File: rtl/wb_adc_pkg.sv
// Shared constants for the Wishbone ADC averaging stage: register indices,
// sample axis tags and CTRL/STATUS bit positions.
package wb_adc_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_X      = 3'd2;
    localparam logic [2:0] REG_Y      = 3'd3;
    localparam logic [2:0] REG_Z      = 3'd4;
    localparam logic [2:0] REG_FRAME  = 3'd5;

    typedef enum logic [1:0] {
        AXIS_X    = 2'd0,
        AXIS_Y    = 2'd1,
        AXIS_Z    = 2'd2,
        AXIS_NONE = 2'd3
    } axis_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STAT_NEW_X = 0;
    localparam int STAT_NEW_Y = 1;
    localparam int STAT_NEW_Z = 2;

endpackage

// File: rtl/adc_axis_avg.sv
// Single-axis box-car averager: sums 2^AVG_LOG2 samples, then latches the
// truncated mean and pulses done combinationally with the completing sample.
module adc_axis_avg #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    // With AVG_LOG2=0 the count never leaves 0, so every sample is the last.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] count;
    logic             last;

    assign sum  = acc + ACC_W'(data);
    assign last = (count == CNT_LAST);
    assign done = enable & valid & last;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            count  <= '0;
            result <= '0;
        end else if (!enable) begin
            acc   <= '0;
            count <= '0;
        end else if (valid) begin
            if (last) begin
                result <= DATA_W'(sum >> AVG_LOG2);
                acc    <= '0;
                count  <= '0;
            end else begin
                acc   <= sum;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_adc_avg.sv
// Wishbone register bank around three per-axis averagers, with sticky
// new-data flags, a z-frame counter and a level interrupt.
module wb_adc_avg
    import wb_adc_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              smp_valid,
    input  logic [1:0]        smp_axis,
    input  logic [DATA_W-1:0] smp_data,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              irq
);

    logic [1:0]        ctrl;
    logic [2:0]        flags;
    logic [2:0]        new_set;
    logic [2:0]        w1c;
    logic [15:0]       frame;
    logic [DATA_W-1:0] res_x, res_y, res_z;
    logic              done_x, done_y, done_z;
    logic              enable;
    logic              access;
    logic              wr;
    logic [2:0]        idx;
    logic [31:0]       rd_data;
    logic              unused;

    assign enable = ctrl[CTRL_EN_BIT];
    // A new access is only taken while ack is low, giving one ack per strobe.
    assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr     = access & wb_we_i;
    assign idx    = wb_adr_i[4:2];
    assign irq    = ctrl[CTRL_IRQ_EN_BIT] & (|flags);
    assign unused = ^{wb_adr_i[1:0], wb_dat_i[31:3]};

    adc_axis_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_x (
        .clk(clk), .reset(reset), .enable(enable),
        .valid(smp_valid && smp_axis == AXIS_X), .data(smp_data),
        .done(done_x), .result(res_x)
    );

    adc_axis_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_y (
        .clk(clk), .reset(reset), .enable(enable),
        .valid(smp_valid && smp_axis == AXIS_Y), .data(smp_data),
        .done(done_y), .result(res_y)
    );

    adc_axis_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_z (
        .clk(clk), .reset(reset), .enable(enable),
        .valid(smp_valid && smp_axis == AXIS_Z), .data(smp_data),
        .done(done_z), .result(res_z)
    );

    always_comb begin
        new_set             = '0;
        new_set[STAT_NEW_X] = done_x;
        new_set[STAT_NEW_Y] = done_y;
        new_set[STAT_NEW_Z] = done_z;
        w1c = (wr && idx == REG_STATUS) ? wb_dat_i[2:0] : 3'b000;
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_CTRL:   rd_data = {30'd0, ctrl};
            REG_STATUS: rd_data = {29'd0, flags};
            REG_X:      rd_data = 32'(res_x);
            REG_Y:      rd_data = 32'(res_y);
            REG_Z:      rd_data = 32'(res_z);
            REG_FRAME:  rd_data = {16'd0, frame};
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            flags    <= '0;
            frame    <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= access;
            // Read mux sees pre-edge results, so a same-cycle update is not visible.
            if (access) wb_dat_o <= rd_data;
            if (wr && idx == REG_CTRL) ctrl <= wb_dat_i[1:0];
            // Set takes priority over a coincident write-1-to-clear.
            flags <= (flags & ~w1c) | new_set;
            if (done_z) frame <= frame + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_adc_avg.sv
// Directed self-checking bench for wb_adc_avg (DATA_W=12, AVG_LOG2=3).
module tb_wb_adc_avg;

    logic        clk = 1'b0;
    logic        reset;
    logic        smp_valid;
    logic [1:0]  smp_axis;
    logic [11:0] smp_data;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [4:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq;

    int tests = 0;
    int fails = 0;

    wb_adc_avg #(.DATA_W(12), .AVG_LOG2(3)) dut (
        .clk(clk), .reset(reset),
        .smp_valid(smp_valid), .smp_axis(smp_axis), .smp_data(smp_data),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
    endtask

    // Ack must rise on the first edge and be gone on the next.
    task automatic wb_access(input logic we, input logic [2:0] idx, input logic [31:0] wdata,
                             output logic [31:0] rdata);
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {idx, 2'b00};
        wb_dat_i = wdata;
        @(posedge clk);
        #1;
        chk("ack_high", {31'd0, wb_ack_o}, 32'd1);
        rdata = wb_dat_o;
        @(negedge clk);
        bus_idle();
        @(posedge clk);
        #1;
        chk("ack_low", {31'd0, wb_ack_o}, 32'd0);
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] wdata);
        logic [31:0] dummy;
        wb_access(1'b1, idx, wdata, dummy);
    endtask

    task automatic wb_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] rd;
        wb_access(1'b0, idx, 32'd0, rd);
        chk(tag, rd, exp);
    endtask

    task automatic smp(input logic [1:0] axis, input logic [11:0] data);
        @(negedge clk);
        smp_valid = 1'b1;
        smp_axis  = axis;
        smp_data  = data;
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        smp_valid = 1'b0;
        smp_axis  = 2'd0;
        smp_data  = '0;
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // All eight registers read zero after reset.
        for (int i = 0; i < 8; i++) wb_check("rst_reg", 3'(i), 32'd0);

        // x average of 100..107: 828/8 = 103 (truncated).
        wb_write(3'd0, 32'h3);
        wb_check("ctrl_rb", 3'd0, 32'h3);
        for (int i = 0; i < 8; i++) smp(2'd0, 12'(100 + i));
        chk("irq_after_x", {31'd0, irq}, 32'd1);
        wb_check("x_avg", 3'd2, 32'd103);
        wb_check("status_x", 3'd1, 32'h1);
        wb_write(3'd1, 32'h1);
        wb_check("status_clr", 3'd1, 32'h0);
        chk("irq_clr", {31'd0, irq}, 32'd0);

        // Interleaved axes at full rate.
        for (int i = 0; i < 8; i++) begin
            smp(2'd0, 12'hFFF);
            smp(2'd1, 12'h000);
            smp(2'd2, 12'h800);
        end
        wb_check("x_max", 3'd2, 32'hFFF);
        wb_check("y_zero", 3'd3, 32'h0);
        wb_check("z_mid", 3'd4, 32'h800);
        wb_check("frame_1", 3'd5, 32'd1);
        wb_check("status_7", 3'd1, 32'h7);
        wb_write(3'd1, 32'h7);

        // Disabled samples are dropped; disable discards partial sums.
        wb_write(3'd0, 32'h2);
        for (int i = 0; i < 16; i++) smp(2'd1, 12'd7);
        wb_write(3'd0, 32'h3);
        for (int i = 0; i < 4; i++) smp(2'd1, 12'd9);
        wb_check("y_held", 3'd3, 32'd0);
        wb_check("status_noy", 3'd1, 32'h0);
        wb_write(3'd0, 32'h2);
        wb_write(3'd0, 32'h3);
        for (int i = 0; i < 8; i++) smp(2'd1, 12'd50);
        wb_check("y_50", 3'd3, 32'd50);
        wb_check("status_y", 3'd1, 32'h2);
        wb_write(3'd1, 32'h2);

        // W1C of new_z on the same edge as the completing z sample.
        for (int i = 0; i < 7; i++) smp(2'd2, 12'h010);
        @(negedge clk);
        smp_valid = 1'b1;
        smp_axis  = 2'd2;
        smp_data  = 12'h010;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = 1'b1;
        wb_adr_i  = {3'd1, 2'b00};
        wb_dat_i  = 32'h4;
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
        chk("ack_w1c", {31'd0, wb_ack_o}, 32'd1);
        @(negedge clk);
        bus_idle();
        wb_check("status_set_wins", 3'd1, 32'h4);
        wb_check("z_10", 3'd4, 32'h10);
        wb_check("frame_2", 3'd5, 32'd2);
        wb_write(3'd1, 32'h4);

        // FRAME wraps from 0xFFFF to 0.
        @(negedge clk);
        force dut.frame = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame;
        wb_check("frame_ffff", 3'd5, 32'hFFFF);
        for (int i = 0; i < 8; i++) smp(2'd2, 12'd1);
        wb_check("frame_wrap", 3'd5, 32'd0);
        wb_check("z_1", 3'd4, 32'd1);
        wb_write(3'd1, 32'h7);

        // Axis-3 samples must not touch any accumulator or flag.
        for (int i = 0; i < 5; i++) smp(2'd3, 12'hABC);
        wb_check("status_ax3", 3'd1, 32'h0);
        for (int i = 0; i < 8; i++) smp(2'd0, 12'd4);
        wb_check("x_4", 3'd2, 32'd4);
        wb_check("status_x2", 3'd1, 32'h1);
        wb_check("y_keep", 3'd3, 32'd50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_adc_avg.md
# wb_adc_avg

Wishbone-readable averaging stage that sits directly downstream of the ADC x/y/z coordinate front-end. It accepts one tagged 12-bit sample per valid strobe, averages each axis over 2^AVG_LOG2 samples, and latches the results into a Wishbone register bank. It also provides per-axis "new data" flags, a frame counter and an interrupt line for the host CPU.

## Interface
- DATA_W, 12, ADC sample width.
- AVG_LOG2, 3, log2 of samples averaged per axis (range 0..6).
- clk  in  1  system / Wishbone clock.
- reset  in  1  synchronous, active-high reset.
- smp_valid  in  1  sample strobe, one cycle per sample.
- smp_axis  in  2  sample tag: 0=x, 1=y, 2=z, 3=ignored.
- smp_data  in  DATA_W  unsigned sample.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  5  byte address; bits [4:2] select the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  single-cycle acknowledge.
- irq  out  1  level interrupt.

## Operation
- Register map (word index = wb_adr_i[4:2]):
  - 0 CTRL, R/W: bit0 enable, bit1 irq_en.
  - 1 STATUS: bits[2:0] new_x/new_y/new_z; write-1-to-clear.
  - 2 X, read-only, average zero-extended.
  - 3 Y, read-only.
  - 4 Z, read-only.
  - 5 FRAME, read-only, 16-bit frame count.
  - 6-7 read 0; writes to them are ignored.
- Per axis: an accumulator of DATA_W+AVG_LOG2 bits and a count of AVG_LOG2 bits.
- Each accepted sample (smp_valid & enable & smp_axis != 3) adds to its axis accumulator and increments that axis count.
- On the 2^AVG_LOG2-th sample, the axis result becomes (acc + sample) >> AVG_LOG2 (truncating). In the same cycle the accumulator and count clear and the axis new flag sets.
- The FRAME counter increments each time the z average completes, and wraps from 0xFFFF to 0.
- AVG_LOG2=0: every sample passes straight through to the result register.
- With enable=0, samples are dropped and all accumulators and counts are held at 0. Result registers, flags and FRAME keep their values.
- Clearing enable mid-average discards the partial sums.
- irq = irq_en & (new_x | new_y | new_z).
- Simultaneous events:
  - Flag set and W1C of the same bit in the same cycle: the set wins, so the flag stays 1.
  - Result update and register read in the same cycle: the read returns the pre-update value.

## Timing
- Reset: wb_dat_o=0, wb_ack_o=0, irq=0. CTRL, STATUS, X, Y, Z, FRAME, all accumulators and all counts are 0.
- Sample to result: the result register and flag update on the clock edge that samples the final valid. They are visible one cycle after that valid, and irq follows in the same cycle.
- Wishbone handshake:
  - wb_ack_o asserts the cycle after wb_cyc_i & wb_stb_i are seen with ack low, and lasts exactly one cycle.
  - The master drops stb after ack. A held stb produces an ack every other cycle.
  - wb_dat_o is valid in the ack cycle.
  - Writes take effect on the edge that raises ack.
- Reset asserted mid-transaction drops ack on the next edge; no write is committed after that edge.
- Throughput: one sample per clock on any axis mix, with no stalls and no backpressure.

## Structure
- Shared package (wb_adc_pkg): register index constants (REG_CTRL..REG_FRAME), the axis encodings AXIS_X/Y/Z/NONE, and the CTRL/STATUS bit positions.
- One sub-module, adc_axis_avg: accumulator, count and result register for a single axis. It has parameters DATA_W and AVG_LOG2 and outputs done (1-cycle) and result.
- The top level instantiates adc_axis_avg three times and adds the Wishbone decode, STATUS/FRAME/irq logic.

## Test plan
- Reset, then read all 8 registers: all return 0, and ack is exactly 1 cycle per access.
- Write CTRL=0x3, then send 8 x samples 100..107 (AVG_LOG2=3): X reads 103, STATUS=0x1, irq=1. Write STATUS=0x1: STATUS=0, irq=0.
- Interleave x/y/z samples, 8 each, with constant values 0xFFF/0x000/0x800: X=0xFFF, Y=0, Z=0x800, FRAME=1, STATUS=0x7.
- With enable=0, send 16 y samples, then enable and send 4: Y stays 0 and new_y=0. Disable mid-average, re-enable, send 8 samples of 50: Y=50.
- Issue the W1C of new_z on the same edge as the 8th z sample: STATUS bit2 reads 1 afterwards.
- Preload FRAME at 0xFFFF via 65535 z-completions (or a force hook), complete one more z average: FRAME=0. Samples tagged axis 3 leave all state unchanged.
